// File: rtl/timing_train_decoder.sv
// Decodes the blackout / scan-beat / digit-pulse train into digit index, beat phase and lock
// status, and flags malformed trains with sticky error bits.
module timing_train_decoder #(
  parameter int unsigned N          = 20,
  parameter int unsigned LOCK_LINES = 2,
  localparam int unsigned W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_dashclk,
  input  logic         i_nreset,
  input  logic         i_bo,
  input  logic         i_hs,
  input  logic [N-1:0] i_ps,
  input  logic         i_err_clr,
  output logic [W-1:0] o_digit,
  output logic         o_digit_valid,
  output logic         o_line_done,
  output logic [1:0]   o_beat,
  output logic         o_locked,
  output logic [3:0]   o_err
);

  typedef enum logic [1:0] {StIdle, StBlank, StRun, StDone} state_e;

  localparam logic [N-1:0] PsOne     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W:0]   LastIdx   = (W+1)'(N - 1);
  localparam logic [W:0]   ExpOne    = (W+1)'(1);
  localparam logic [3:0]   LockLines = 4'(LOCK_LINES);

  state_e       r_state;
  logic         r_bo_d;
  logic [W:0]   r_expect;
  logic         r_dirty;
  logic [3:0]   r_lock_cnt;
  logic [W-1:0] r_digit;
  logic         r_digit_valid;
  logic         r_line_done;
  logic [1:0]   r_beat;
  logic         r_locked;
  logic [3:0]   r_err;

  logic         w_bor;
  logic         w_any;
  logic         w_multi;
  logic         w_single;
  logic [W-1:0] w_idx;
  logic         w_run;
  logic         w_match;
  logic         w_accept;
  logic         w_adv;
  logic [1:0]   w_beat_inc;
  logic         w_phase_err;
  logic         w_clean_close;
  logic [3:0]   w_lock_inc;
  logic [3:0]   w_err_new;

  always_comb begin
    w_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_ps[k]) w_idx = W'(k);
    end
    w_bor         = i_bo & ~r_bo_d;
    w_any         = |i_ps;
    w_multi       = |(i_ps & (i_ps - PsOne));
    w_single      = w_any & ~w_multi;
    // BLANK with bo already low behaves as RUN so p0 may coincide with the falling edge
    w_run         = ((r_state == StBlank) || (r_state == StRun)) && !i_bo;
    w_match       = w_single && ({1'b0, w_idx} == r_expect);
    w_accept      = w_run && w_match;
    w_adv         = w_bor && ((r_state == StRun) || (r_state == StDone));
    w_beat_inc    = r_beat + 2'd1;
    w_phase_err   = w_adv && (i_hs == w_beat_inc[0]);
    w_clean_close = w_bor && (r_state == StDone) && !r_dirty;
    w_lock_inc    = (r_lock_cnt == 4'hf) ? 4'hf : r_lock_cnt + 4'd1;
    w_err_new[0]  = (i_bo && w_any) || (w_run && w_single && !w_match) ||
                    ((r_state == StDone) && w_any);
    w_err_new[1]  = w_run && w_multi;
    w_err_new[2]  = w_bor && (r_state == StRun);
    w_err_new[3]  = w_phase_err;
  end

  always_ff @(posedge i_dashclk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state       <= StIdle;
      r_bo_d        <= 1'b0;
      r_expect      <= '0;
      r_dirty       <= 1'b0;
      r_lock_cnt    <= 4'd0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_line_done   <= 1'b0;
      r_beat        <= 2'd0;
      r_locked      <= 1'b0;
      r_err         <= 4'd0;
    end else begin
      r_bo_d        <= i_bo;
      r_digit_valid <= w_accept;
      r_line_done   <= w_accept && (r_expect == LastIdx) && !r_dirty;
      if (w_accept) r_digit <= w_idx;
      r_err <= (i_err_clr ? 4'd0 : r_err) | w_err_new;

      if (|w_err_new) begin
        r_lock_cnt <= 4'd0;
        r_locked   <= 1'b0;
      end else if (w_clean_close) begin
        r_lock_cnt <= w_lock_inc;
        r_locked   <= (w_lock_inc >= LockLines);
      end

      if (w_adv) r_beat <= w_phase_err ? {w_beat_inc[1], ~i_hs} : w_beat_inc;

      if (w_bor) begin
        // a pulse sampled with the new blackout belongs to the new line's blanking
        r_state  <= StBlank;
        r_expect <= '0;
        r_dirty  <= w_any;
      end else begin
        case (r_state)
          StIdle: ;
          StBlank, StRun: begin
            if (i_bo) begin
              if (w_any) r_dirty <= 1'b1;
            end else begin
              r_state <= (w_accept && (r_expect == LastIdx)) ? StDone : StRun;
              if (w_accept) r_expect <= r_expect + ExpOne;
              else if (w_any) r_dirty <= 1'b1;
            end
          end
          StDone: if (w_any) r_dirty <= 1'b1;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_digit       = r_digit;
  assign o_digit_valid = r_digit_valid;
  assign o_line_done   = r_line_done;
  assign o_beat        = r_beat;
  assign o_locked      = r_locked;
  assign o_err         = r_err;

endmodule

// File: tb/tb_timing_train_decoder.sv
// Bench for timing_train_decoder: hand vector table, directed line sequences and randomized
// lines, every cycle checked against a line-level reference model.
module tb_timing_train_decoder;

  localparam int unsigned N  = 20;
  localparam int unsigned LL = 2;
  localparam int unsigned W  = $clog2(N);

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         bo = 1'b0;
  logic         hs = 1'b0;
  logic [N-1:0] ps = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] digit;
  logic         digit_valid;
  logic         line_done;
  logic [1:0]   beat;
  logic         locked;
  logic [3:0]   err;

  timing_train_decoder #(.N(N), .LOCK_LINES(LL)) dut (
    .i_dashclk(clk), .i_nreset(nreset), .i_bo(bo), .i_hs(hs), .i_ps(ps), .i_err_clr(err_clr),
    .o_digit(digit), .o_digit_valid(digit_valid), .o_line_done(line_done), .o_beat(beat),
    .o_locked(locked), .o_err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  int ldcnt   = 0;

  // Reference model: line-level view (started, next expected digit, dirty, beat, lock count)
  bit       m_started, m_dirty, m_bo_prev, m_valid, m_ldone;
  int       m_next, m_beat, m_lock, m_digit;
  bit [3:0] m_err;

  function automatic void model_reset();
    m_started = 0; m_dirty = 0; m_bo_prev = 0; m_valid = 0; m_ldone = 0;
    m_next = 0; m_beat = 0; m_lock = 0; m_digit = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit b, input bit h, input logic [N-1:0] p,
                                     input bit clr);
    bit       bor = b && !m_bo_prev;
    bit       clean_close = 0;
    bit [3:0] ne = 0;
    int       cnt = $countones(p);
    int       idx = 0;
    for (int k = 0; k < N; k++) if (p[k]) idx = k;
    m_valid = 0;
    m_ldone = 0;
    if (b && cnt > 0) ne[0] = 1;
    if (bor) begin
      if (m_started) begin
        if (m_next < N) ne[2] = 1;
        clean_close = (m_next == N) && !m_dirty;
        m_beat = (m_beat + 1) % 4;
        if (h != (m_beat % 2 == 0)) begin
          ne[3]  = 1;
          m_beat = (m_beat & 2) | (h ? 0 : 1);
        end
      end
      m_started = 1; m_next = 0; m_dirty = (cnt > 0);
    end else if (m_started && cnt > 0) begin
      if (b) m_dirty = 1;
      else if (m_next == N) begin ne[0] = 1; m_dirty = 1; end
      else if (cnt > 1) begin ne[1] = 1; m_dirty = 1; end
      else if (idx != m_next) begin ne[0] = 1; m_dirty = 1; end
      else begin
        m_digit = idx; m_valid = 1; m_ldone = (idx == N - 1) && !m_dirty; m_next++;
      end
    end
    if (ne != 0) m_lock = 0;
    else if (clean_close && m_lock < 15) m_lock++;
    m_err = (clr ? 4'b0 : m_err) | ne;
    m_bo_prev = b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input bit b, input bit h, input logic [N-1:0] p, input bit clr);
    bo = b; hs = h; ps = p; err_clr = clr;
    model_step(b, h, p, clr);
    @(posedge clk);
    #1;
    if (digit_valid) vcnt++;
    if (line_done) ldcnt++;
    check("cycle", 32'({err, locked, beat, line_done, digit_valid, digit}),
          32'({m_err, (m_lock >= LL), 2'(m_beat), m_ldone, m_valid, W'(m_digit)}));
  endtask

  task automatic do_reset(input int cycles);
    bo = 0; hs = 0; ps = '0; err_clr = 0;
    nreset = 0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset", 32'({err, locked, beat, line_done, digit_valid, digit}), 32'd0);
    end
    nreset = 1;
  endtask

  function automatic bit hs_next();
    return ((m_beat + 1) % 2) == 0;
  endfunction

  // One line: blackout, then p0..p(stop) with an optional skipped digit or doubled sample
  task automatic run_line(input int bo_cyc, input bit h, input int skip, input int multi_at,
                          input int stop, input bit rnd);
    logic [N-1:0] p;
    for (int i = 0; i < bo_cyc; i++) step(1, h, '0, 0);
    for (int k = 0; k <= stop; k++) begin
      p = '0;
      if (k == skip) continue;
      if (k == multi_at && k + 1 < N) begin p[k] = 1; p[k+1] = 1; k++; end
      else p[k] = 1;
      if (rnd) begin
        if ($urandom_range(0, 9) == 0) step(0, h, '0, 0);
        if ($urandom_range(0, 29) == 0) p[$urandom_range(0, N - 1)] = 1'b1;
      end
      step(0, h, p, rnd && ($urandom_range(0, 19) == 0));
    end
    step(0, h, '0, 0);
  endtask

  typedef struct {
    bit       b;
    bit       h;
    int       pa;
    int       pb;
    bit       clr;
    int       e_digit;
    bit       e_valid;
    int       e_beat;
    bit [3:0] e_err;
  } vec_t;

  vec_t tbl[13];
  int   v0, l0;

  initial begin
    tbl[0]  = '{1, 1, -1, -1, 0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{1, 1, -1, -1, 0, 0, 0, 0, 4'b0000};
    tbl[2]  = '{0, 1,  0, -1, 0, 0, 1, 0, 4'b0000};
    tbl[3]  = '{0, 1,  1, -1, 0, 1, 1, 0, 4'b0000};
    tbl[4]  = '{0, 1,  2, -1, 0, 2, 1, 0, 4'b0000};
    tbl[5]  = '{0, 1,  3,  4, 0, 2, 0, 0, 4'b0010};
    tbl[6]  = '{0, 1,  3, -1, 0, 3, 1, 0, 4'b0010};
    tbl[7]  = '{0, 1, -1, -1, 0, 3, 0, 0, 4'b0010};
    tbl[8]  = '{0, 1,  5, -1, 0, 3, 0, 0, 4'b0011};
    tbl[9]  = '{0, 1, -1, -1, 1, 3, 0, 0, 4'b0000};
    tbl[10] = '{0, 1,  4, -1, 0, 4, 1, 0, 4'b0000};
    tbl[11] = '{1, 0, -1, -1, 0, 4, 0, 1, 4'b0100};
    tbl[12] = '{1, 0,  7, -1, 1, 4, 0, 1, 4'b0001};

    do_reset(2);
    for (int i = 0; i < 13; i++) begin
      logic [N-1:0] p;
      p = '0;
      if (tbl[i].pa >= 0) p[tbl[i].pa] = 1'b1;
      if (tbl[i].pb >= 0) p[tbl[i].pb] = 1'b1;
      step(tbl[i].b, tbl[i].h, p, tbl[i].clr);
      check($sformatf("vec%0d", i),
            32'({digit, digit_valid, beat, err}),
            32'({W'(tbl[i].e_digit), tbl[i].e_valid, 2'(tbl[i].e_beat), tbl[i].e_err}));
    end

    // Clean stream with correct hs, then a flipped hs on the sixth line
    do_reset(3);
    v0 = vcnt; l0 = ldcnt;
    for (int i = 0; i < 5; i++) begin
      run_line(4, (i % 2) == 0, -1, -1, N - 1, 0);
      check($sformatf("beat_line%0d", i), 32'(beat), 32'(i % 4));
      if (i == 1) check("locked_after_1", 32'(locked), 32'd0);
      if (i == 2) check("locked_after_2", 32'(locked), 32'd1);
    end
    check("clean_valids", 32'(vcnt - v0), 32'(5 * N));
    check("clean_line_done", 32'(ldcnt - l0), 32'd5);
    check("clean_err", 32'(err), 32'd0);
    run_line(4, 1'b1, -1, -1, N - 1, 0);
    check("phase_err", 32'({err, beat, locked}), 32'({4'b1000, 2'd0, 1'b0}));

    // Skipped digit
    step(0, 0, '0, 1);
    l0 = ldcnt;
    run_line(4, hs_next(), 7, -1, N - 1, 0);
    check("skip_err", 32'(err), 32'b0001);
    check("skip_no_done", 32'(ldcnt - l0), 32'd0);
    run_line(4, hs_next(), -1, -1, N - 1, 0);
    check("after_skip_done", 32'(ldcnt - l0), 32'd1);
    run_line(4, hs_next(), -1, -1, N - 1, 0);
    check("relock_1", 32'(locked), 32'd0);
    run_line(4, hs_next(), -1, -1, N - 1, 0);
    check("relock_2", 32'(locked), 32'd1);

    // Doubled sample, then truncated line, then clean line
    step(0, 0, '0, 1);
    run_line(3, hs_next(), -1, 3, N - 1, 0);
    check("multi_err1", 32'(err[1]), 32'd1);
    check("multi_digit", 32'(digit), 32'd2);
    run_line(3, hs_next(), -1, -1, 11, 0);
    check("multi_missing", 32'(err[2]), 32'd1);
    step(0, 0, '0, 1);
    l0 = ldcnt;
    run_line(3, hs_next(), -1, -1, N - 1, 0);
    check("trunc_missing", 32'(err[2]), 32'd1);
    check("trunc_recover", 32'({digit, 1'b0}), 32'({W'(N - 1), 1'b0}));
    check("trunc_done", 32'(ldcnt - l0), 32'd1);

    // Reset mid-line, then clear coincident with a new order error
    run_line(4, hs_next(), -1, -1, 9, 0);
    do_reset(3);
    run_line(4, 1'b1, -1, 3, 5, 0);
    check("pre_clr_err", 32'(err), 32'b0011);
    step(0, 1, N'(1), 1);
    check("clr_with_order", 32'(err), 32'b0001);

    // Randomized lines with occasional faults
    for (int i = 0; i < 40; i++) begin
      bit h = hs_next();
      int skip  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      int multi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 2)) : -1;
      int stop  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : N - 1;
      if ($urandom_range(0, 9) == 0) h = ~h;
      run_line(int'($urandom_range(1, 5)), h, skip, multi, stop, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
